// File: rtl/ws2812_frame_tx_if.sv
// Frame-RAM read port plus frame control/status for the WS2812 frame transmitter.
// master: the system side (start, RAM read data); slave: the transmitter.
interface ws2812_frame_tx_if #(
  parameter int ADDR = 8
);
  logic            start;
  logic [ADDR-1:0] pix_addr;
  logic [23:0]     pix_data;
  logic            busy;
  logic            done;
  logic            led_dout;

  modport master (
    output start,
    output pix_data,
    input  pix_addr,
    input  busy,
    input  done,
    input  led_dout
  );

  modport slave (
    input  start,
    input  pix_data,
    output pix_addr,
    output busy,
    output done,
    output led_dout
  );
endinterface

// File: rtl/ws2812_frame_tx.sv
// Walks the pixel frame RAM and serialises each 24-bit word MSB first onto a WS2812 line, then latches.
// Optional build macro LED_AUTO_REFRESH_EN: after the first start, frames repeat back to back forever.
module ws2812_frame_tx #(
  parameter int NUM_LEDS = 256,
  parameter int ADDR     = 8,
  parameter int T0H_CYC  = 60,
  parameter int T1H_CYC  = 120,
  parameter int TBIT_CYC = 188,
  parameter int TRST_CYC = 7500
) (
  input  logic               clk,
  input  logic               rst_n,
  ws2812_frame_tx_if.slave   bus
);

  localparam int CNT_MAX = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRST_CYC - 1);
  localparam logic [CNT_W-1:0] T0H       = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H       = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(1);

  localparam logic [ADDR-1:0] LAST_PIX  = ADDR'(NUM_LEDS - 1);
  // A one-pixel frame never needs a second word, so the prefetch address stays at 0.
  localparam logic [ADDR-1:0] PREFETCH0 = (NUM_LEDS > 1) ? ADDR'(1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [4:0]       bit_cnt_reg, bit_cnt_next;
  logic [ADDR-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [ADDR-1:0]  pix_addr_reg, pix_addr_next;
  logic [23:0]      shift_reg, shift_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             led_dout_reg, led_dout_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cyc_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      pix_cnt_reg  <= '0;
      pix_addr_reg <= '0;
      shift_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      led_dout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      pix_cnt_reg  <= pix_cnt_next;
      pix_addr_reg <= pix_addr_next;
      shift_reg    <= shift_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      led_dout_reg <= led_dout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    pix_cnt_next  = pix_cnt_reg;
    pix_addr_next = pix_addr_reg;
    shift_next    = shift_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    led_dout_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_FETCH;
          busy_next     = 1'b1;
          cyc_cnt_next  = '0;
          pix_cnt_next  = '0;
          pix_addr_next = '0;
        end
      end

      // Two cycles: one for the RAM to register address 0, one to see its data.
      ST_FETCH: begin
        if (cyc_cnt_reg == FETCH_LAST) begin
          state_next    = ST_SEND;
          shift_next    = bus.pix_data;
          cyc_cnt_next  = '0;
          bit_cnt_next  = '0;
          pix_addr_next = PREFETCH0;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end

      ST_SEND: begin
        if (cyc_cnt_reg == TBIT_LAST) begin
          cyc_cnt_next = '0;
          if (bit_cnt_reg == 5'd23) begin
            bit_cnt_next = '0;
            if (pix_cnt_reg != LAST_PIX) begin
              // Prefetched word has been stable for a whole pixel time; no gap between pixels.
              shift_next   = bus.pix_data;
              pix_cnt_next = pix_cnt_reg + 1'b1;
              if (pix_addr_reg != LAST_PIX) begin
                pix_addr_next = pix_addr_reg + 1'b1;
              end
            end else begin
              state_next = ST_LATCH;
            end
          end else begin
            shift_next   = {shift_reg[22:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end

      ST_LATCH: begin
        if (cyc_cnt_reg == TRST_LAST) begin
          done_next     = 1'b1;
          cyc_cnt_next  = '0;
          pix_addr_next = '0;
`ifdef LED_AUTO_REFRESH_EN
          state_next    = ST_FETCH;
          pix_cnt_next  = '0;
`else
          state_next    = ST_IDLE;
          busy_next     = 1'b0;
`endif
        end else begin
          cyc_cnt_next = cyc_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Output register tracks the upcoming state so the line is aligned with cyc_cnt.
    if (state_next == ST_SEND) begin
      led_dout_next = (cyc_cnt_next < (shift_next[23] ? T1H : T0H));
    end
  end

  assign bus.pix_addr = pix_addr_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.led_dout = led_dout_reg;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: a 3-pixel and a 1-pixel instance, cycle-exact scoreboard of the line,
// done, busy and pix_addr, plus a per-frame high-time total taken from the vector table.
module tb_ws2812_frame_tx;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TRST = 10;

  typedef struct {
    logic       led;
    logic       done;
    logic       busy;
    logic [7:0] addr;
  } sb_t;

  typedef struct {
    bit          sel;      // 0: 3-pixel instance, 1: 1-pixel instance
    logic [23:0] p0;
    logic [23:0] p1;
    logic [23:0] p2;
    int          ra;       // cycles at which start is re-pulsed mid-frame (0 = none)
    int          rb;
    int          exp_high; // total led high cycles in the frame
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ws2812_frame_tx_if #(.ADDR(8)) if_a ();
  ws2812_frame_tx_if #(.ADDR(8)) if_b ();

  ws2812_frame_tx #(
    .NUM_LEDS(3), .ADDR(8), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );

  ws2812_frame_tx #(
    .NUM_LEDS(1), .ADDR(8), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  logic [23:0] mem_a [256];
  logic [23:0] mem_b [256];

  always @(posedge clk) begin
    if_a.pix_data <= mem_a[if_a.pix_addr];
    if_b.pix_data <= mem_b[if_b.pix_addr];
  end

  sb_t  sb_a[$];
  sb_t  sb_b[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   hi_a   = 0;
  int   hi_b   = 0;
  int   cyc    = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      check("a_led", 32'(if_a.led_dout), 32'(e.led));
      check("a_done", 32'(if_a.done), 32'(e.done));
      check("a_busy", 32'(if_a.busy), 32'(e.busy));
      check("a_addr", 32'(if_a.pix_addr), 32'(e.addr));
      if (if_a.led_dout === 1'b1) hi_a++;
    end
    if (sb_b.size() > 0) begin
      e = sb_b.pop_front();
      check("b_led", 32'(if_b.led_dout), 32'(e.led));
      check("b_done", 32'(if_b.done), 32'(e.done));
      check("b_busy", 32'(if_b.busy), 32'(e.busy));
      check("b_addr", 32'(if_b.pix_addr), 32'(e.addr));
      if (if_b.led_dout === 1'b1) hi_b++;
    end
  endtask

  // Expected state after each edge, starting with the edge that samples start.
  task automatic push_frame(input bit sel, input int n, input logic [23:0] p0,
                            input logic [23:0] p1, input logic [23:0] p2);
    logic [23:0] px [3];
    sb_t e;
    px[0] = p0;
    px[1] = p1;
    px[2] = p2;
    for (int k = 0; k < 2; k++) begin
      e.led = 1'b0; e.done = 1'b0; e.busy = 1'b1; e.addr = 8'd0;
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    for (int j = 0; j < 24 * n * TBIT; j++) begin
      int   p;
      int   b;
      int   c;
      logic bv;
      p  = j / (24 * TBIT);
      b  = (j / TBIT) % 24;
      c  = j % TBIT;
      bv = px[p][23 - b];
      e.led  = (c < (bv ? T1H : T0H));
      e.done = 1'b0;
      e.busy = 1'b1;
      e.addr = 8'((p + 1 < n - 1) ? p + 1 : n - 1);
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    for (int k = 0; k < TRST; k++) begin
      e.led = 1'b0; e.done = 1'b0; e.busy = 1'b1; e.addr = 8'(n - 1);
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end
    e.led = 1'b0; e.done = 1'b1; e.busy = 1'b0; e.addr = 8'd0;
    if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    e.done = 1'b0;
    if (sel) sb_b.push_back(e); else sb_a.push_back(e);
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int   n;
    int   total;
    int   hi0;
    v = vecs[idx];
    n = v.sel ? 1 : 3;
    if (v.sel) begin
      mem_b[0] = v.p0;
    end else begin
      mem_a[0] = v.p0; mem_a[1] = v.p1; mem_a[2] = v.p2;
    end
    total = 2 + 24 * n * TBIT + TRST + 2;
    hi0 = v.sel ? hi_b : hi_a;
    push_frame(v.sel, n, v.p0, v.p1, v.p2);
    if (v.sel) if_b.start = 1'b1; else if_a.start = 1'b1;
    step();
    for (int k = 1; k < total; k++) begin
      if (v.sel) if_b.start = (k == v.ra || k == v.rb);
      else       if_a.start = (k == v.ra || k == v.rb);
      step();
    end
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    check("sb_drained", 32'(v.sel ? sb_b.size() : sb_a.size()), 32'd0);
    check("high_total", 32'((v.sel ? hi_b : hi_a) - hi0), 32'(v.exp_high));
    $display("frame %0d: dut=%0d pixels=%06h %06h %06h high=%0d checks=%0d failures=%0d",
             idx, v.sel, v.p0, v.p1, v.p2, (v.sel ? hi_b : hi_a) - hi0, n_chk, n_fail);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, p0: 24'hFF0000, p1: 24'h000000, p2: 24'hA5A5A5, ra: 0, rb: 0,   exp_high: 184};
    vecs[1] = '{sel: 1'b0, p0: 24'hFF0000, p1: 24'h000000, p2: 24'hA5A5A5, ra: 5, rb: 100, exp_high: 184};
    vecs[2] = '{sel: 1'b0, p0: 24'h000000, p1: 24'h000000, p2: 24'h000000, ra: 0, rb: 0,   exp_high: 144};
    vecs[3] = '{sel: 1'b0, p0: 24'hFFFFFF, p1: 24'hFFFFFF, p2: 24'hFFFFFF, ra: 0, rb: 0,   exp_high: 288};
    vecs[4] = '{sel: 1'b0, p0: 24'h123456, p1: 24'h789ABC, p2: 24'hDEF012, ra: 0, rb: 0,   exp_high: 212};
    vecs[5] = '{sel: 1'b1, p0: 24'h800001, p1: 24'h000000, p2: 24'h000000, ra: 0, rb: 0,   exp_high: 52};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 24'h5A5A5A;
      mem_b[i] = 24'h5A5A5A;
    end
    rst_n      = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (3) step();
    check("rst_a_led", 32'(if_a.led_dout), 32'd0);
    check("rst_a_busy", 32'(if_a.busy), 32'd0);
    check("rst_a_done", 32'(if_a.done), 32'd0);
    check("rst_a_addr", 32'(if_a.pix_addr), 32'd0);
    check("rst_b_led", 32'(if_b.led_dout), 32'd0);
    check("rst_b_busy", 32'(if_b.busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) begin
      run_frame(i);
      repeat (3) step();
    end

    // Reset in the middle of pixel 1, bit 3, while the line is high.
    mem_a[0] = 24'hFF0000; mem_a[1] = 24'h000000; mem_a[2] = 24'hA5A5A5;
    push_frame(1'b0, 3, 24'hFF0000, 24'h000000, 24'hA5A5A5);
    if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    repeat (165) step();
    check("pre_rst_led", 32'(if_a.led_dout), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_led", 32'(if_a.led_dout), 32'd0);
    check("midrst_busy", 32'(if_a.busy), 32'd0);
    check("midrst_addr", 32'(if_a.pix_addr), 32'd0);
    $display("mid-frame reset: led=%0b busy=%0b addr=%0d", if_a.led_dout, if_a.busy, if_a.pix_addr);
    sb_a.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
